// File: rtl/eth_mac_rx_frame_buffer.sv
// Store-and-forward rx frame buffer: commits only good, fitting frames; first byte out 2 cycles after tlast.
// Input has no backpressure (overflowing frames are dropped); output honours m_axis_tready. Optional stats: ETH_MAC_RX_FRAME_BUFFER_STATS_EN.
module eth_mac_rx_frame_buffer #(
  parameter int ADDR_WIDTH            = 12,
  parameter int OUTPUT_LAST_ONLY_GOOD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_good_frame,
  output logic       status_bad_frame,
  output logic       status_overflow
`ifdef ETH_MAC_RX_FRAME_BUFFER_STATS_EN
  ,
  output logic [31:0] stat_good_count,
  output logic [31:0] stat_bad_count,
  output logic [31:0] stat_overflow_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  if (ADDR_WIDTH < 4 || ADDR_WIDTH > 16) begin : g_bad_addr_width
    $error("eth_mac_rx_frame_buffer: ADDR_WIDTH must be 4..16");
  end
  if (OUTPUT_LAST_ONLY_GOOD != 1) begin : g_bad_only_good
    $error("eth_mac_rx_frame_buffer: only OUTPUT_LAST_ONLY_GOOD=1 is supported");
  end

  typedef enum logic {RECV, DROP} wr_state_t;

  logic [8:0]          mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_cur;
  logic [ADDR_WIDTH:0] wr_ptr_commit;
  logic [ADDR_WIDTH:0] rd_ptr;
  wr_state_t           wr_state;
  logic                full;
  logic                empty;
  logic                mem_we;
  logic                rd_load;

  // Full uses the live rd_ptr, so a same-cycle read only frees space next cycle.
  assign full    = wr_ptr_cur == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]};
  assign empty   = rd_ptr == wr_ptr_commit;
  assign mem_we  = !rst && wr_state == RECV && s_axis_tvalid && !full;
  assign rd_load = !empty && (!m_axis_tvalid || m_axis_tready);

  assign m_axis_tuser = 1'b0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state          <= RECV;
      wr_ptr_cur        <= '0;
      wr_ptr_commit     <= '0;
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
    end else begin
      status_good_frame <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_overflow   <= 1'b0;
      case (wr_state)
        RECV: begin
          if (s_axis_tvalid) begin
            if (!full) begin
              wr_ptr_cur <= wr_ptr_cur + PTR_ONE;
              if (s_axis_tlast) begin
                if (!s_axis_tuser) begin
                  wr_ptr_commit     <= wr_ptr_cur + PTR_ONE;
                  status_good_frame <= 1'b1;
                end else begin
                  wr_ptr_cur       <= wr_ptr_commit;
                  status_bad_frame <= 1'b1;
                end
              end
            end else begin
              // Out of space: rewind and discard the rest of this frame.
              wr_ptr_cur <= wr_ptr_commit;
              if (s_axis_tlast) begin
                status_overflow <= 1'b1;
              end else begin
                wr_state <= DROP;
              end
            end
          end
        end
        DROP: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            status_overflow <= 1'b1;
            wr_state        <= RECV;
          end
        end
        default: wr_state <= RECV;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (rd_load) begin
      {m_axis_tlast, m_axis_tdata} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      m_axis_tvalid                <= 1'b1;
      rd_ptr                       <= rd_ptr + PTR_ONE;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef ETH_MAC_RX_FRAME_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_good_count     <= '0;
      stat_bad_count      <= '0;
      stat_overflow_count <= '0;
    end else begin
      if (status_good_frame && stat_good_count != 32'hFFFF_FFFF) begin
        stat_good_count <= stat_good_count + 32'd1;
      end
      if (status_bad_frame && stat_bad_count != 32'hFFFF_FFFF) begin
        stat_bad_count <= stat_bad_count + 32'd1;
      end
      if (status_overflow && stat_overflow_count != 32'hFFFF_FFFF) begin
        stat_overflow_count <= stat_overflow_count + 32'd1;
      end
    end
  end
`endif

endmodule
